// File: rtl/ov7670_frame_ctrl.sv
// Per-frame capture scheduler for an OV7670 camera on the pixel clock: settle, arm, vsync-aligned capture, geometry check.
// Optional watchdog enabled by defining OV7670_FRAME_TIMEOUT_EN.
module ov7670_frame_ctrl #(
    parameter int SETTLE_FRAMES  = 2,
    parameter int LINES          = 480,
    parameter int BYTES_PER_LINE = 1280,
    parameter int TIMEOUT_CYC    = 2000000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       href,
    input  logic       start,
    input  logic       continuous,
    output logic       cap_en,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] frame_cnt,
    output logic       timeout
);

    typedef enum logic [1:0] {SETTLE, IDLE, ARM, CAPTURE} state_t;

    localparam int SW = $clog2(SETTLE_FRAMES + 2);
    localparam int LW = $clog2(LINES + 2);
    localparam int BW = $clog2(BYTES_PER_LINE + 2);

    localparam logic [SW-1:0] SETTLE_N  = SW'(SETTLE_FRAMES);
    localparam logic [LW-1:0] LINES_N   = LW'(LINES);
    localparam logic [LW-1:0] LINE_SAT  = LW'(LINES + 1);
    localparam logic [BW-1:0] BPL_N     = BW'(BYTES_PER_LINE);
    localparam logic [BW-1:0] BYTE_SAT  = BW'(BYTES_PER_LINE + 1);

    state_t          state, state_next;
    logic            vsync_d, href_d, start_d;
    logic            vs_rise, vs_fall, href_fall, start_rise;
    logic [SW-1:0]   settle_cnt;
    logic [LW-1:0]   line_cnt, line_next;
    logic [BW-1:0]   byte_cnt;
    logic            bad, bad_next;
    logic            cap_en_next, busy_next, done_next, err_next;
    logic            wd_hit;

    assign vs_rise    = vsync & ~vsync_d;
    assign vs_fall    = ~vsync & vsync_d;
    assign href_fall  = ~href & href_d;
    assign start_rise = start & ~start_d;

`ifdef OV7670_FRAME_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt;
    logic          wd_active, vs_any;

    assign wd_active = (state == ARM) || (state == CAPTURE);
    assign vs_any    = vs_rise | vs_fall;
    assign wd_hit    = wd_active && !vs_any && (wd_cnt == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (!wd_active || vs_any || wd_hit) wd_cnt <= '0;
            else                                wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit) timeout <= 1'b1;
        end
    end
`else
    // Watchdog compiled out: ARM/CAPTURE wait indefinitely.
    assign wd_hit  = 1'b0;
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= SETTLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            SETTLE:  if (settle_cnt == SETTLE_N) state_next = IDLE;
            IDLE:    if (continuous ? start : start_rise) state_next = ARM;
            ARM: begin
                if (wd_hit || !start) state_next = IDLE;
                else if (vs_fall)     state_next = CAPTURE;
            end
            CAPTURE: begin
                if (wd_hit)       state_next = IDLE;
                else if (vs_rise) state_next = (continuous && start) ? ARM : IDLE;
            end
            default: state_next = SETTLE;
        endcase
    end

    // A line ending in the same cycle as vs_rise is counted before the frame is judged.
    always_comb begin
        line_next = line_cnt;
        bad_next  = bad;
        if (href_fall) begin
            if (byte_cnt != BPL_N)    bad_next  = 1'b1;
            if (line_cnt != LINE_SAT) line_next = line_cnt + 1'b1;
        end
    end

    always_comb begin
        cap_en_next = (state_next == CAPTURE);
        busy_next   = (state_next == ARM) || (state_next == CAPTURE);
        done_next   = (state == CAPTURE) && vs_rise && !wd_hit;
        err_next    = bad_next || (line_next != LINES_N);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            start_d    <= 1'b0;
            settle_cnt <= '0;
            line_cnt   <= '0;
            byte_cnt   <= '0;
            bad        <= 1'b0;
            cap_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_d    <= vsync;
            href_d     <= href;
            start_d    <= start;
            cap_en     <= cap_en_next;
            busy       <= busy_next;
            frame_done <= done_next;
            frame_err  <= done_next && err_next;
            if (done_next) frame_cnt <= frame_cnt + 8'd1;

            if (state == SETTLE && vs_rise && settle_cnt != SETTLE_N)
                settle_cnt <= settle_cnt + 1'b1;

            if (state == ARM && vs_fall) begin
                line_cnt <= '0;
                byte_cnt <= '0;
                bad      <= 1'b0;
            end else if (state == CAPTURE) begin
                line_cnt <= line_next;
                bad      <= bad_next;
                if (href_fall)                     byte_cnt <= '0;
                else if (href && byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Directed bench for ov7670_frame_ctrl with LINES=4, BYTES_PER_LINE=8, SETTLE_FRAMES=2, TIMEOUT_CYC=100.
// Frame-level vector table plus hand sequences for reset mid-capture, counter wrap and the watchdog.
module tb_ov7670_frame_ctrl;

    localparam int LINES = 4;
    localparam int BPL   = 8;

    logic       pclk = 1'b0;
    logic       rst_n, vsync, href, start, continuous;
    logic       cap_en, busy, frame_done, frame_err, timeout;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int done_seen, href_ticks, cap_hi;
    bit err_last, err_any;

    ov7670_frame_ctrl #(
        .SETTLE_FRAMES(2), .LINES(LINES), .BYTES_PER_LINE(BPL), .TIMEOUT_CYC(100)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .start(start),
        .continuous(continuous), .cap_en(cap_en), .busy(busy), .frame_done(frame_done),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .timeout(timeout)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit start; bit cont; bit drop;
        int nl; int sl; int sb; int tail;
        int exp_done; bit exp_err; int exp_cnt; bit exp_cap; bit exp_busy;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample outputs 1 time unit after the rising edge, before the caller drives new inputs.
    task automatic tick();
        @(posedge pclk);
        #1;
        if (frame_done) begin
            done_seen++;
            err_last = frame_err;
            err_any  = err_any | frame_err;
        end
        if (href) href_ticks++;
        if (href && cap_en) cap_hi++;
    endtask

    task automatic clear_obs();
        done_seen = 0; href_ticks = 0; cap_hi = 0; err_last = 0; err_any = 0;
    endtask

    // Lines with vsync low, then vsync high for 6 cycles (end of frame), then vsync low again.
    task automatic run_frame(input int nl, input int sl, input int sb, input int tail, input bit drop);
        for (int l = 0; l < nl; l++) begin
            href = 1'b1;
            repeat ((l == sl) ? sb : BPL) tick();
            href = 1'b0;
            if (drop && l == 0) start = 1'b0;
            if (l != nl - 1) repeat (2) tick();
        end
        repeat (tail) tick();
        vsync = 1'b1;
        repeat (6) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        //            st cn dr nl sl sb tl  done err cnt cap busy
        vecs[0]  = '{1, 1, 0, 4, -1, 0, 2,  0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 4, -1, 0, 2,  0, 0, 0, 0, 1};
        vecs[2]  = '{1, 1, 0, 4, -1, 0, 2,  1, 0, 1, 1, 1};
        vecs[3]  = '{1, 1, 0, 4,  1, 7, 2,  1, 1, 2, 1, 1};
        vecs[4]  = '{1, 1, 0, 4, -1, 0, 2,  1, 0, 3, 1, 1};
        vecs[5]  = '{1, 1, 0, 5, -1, 0, 2,  1, 1, 4, 1, 1};
        vecs[6]  = '{1, 1, 0, 3, -1, 0, 2,  1, 1, 5, 1, 1};
        vecs[7]  = '{1, 1, 0, 4, -1, 0, 0,  1, 0, 6, 1, 1};
        vecs[8]  = '{1, 1, 0, 4,  3, 7, 0,  1, 1, 7, 1, 1};
        vecs[9]  = '{1, 1, 1, 4, -1, 0, 2,  1, 0, 8, 1, 0};
        vecs[10] = '{0, 0, 0, 4, -1, 0, 2,  0, 0, 8, 0, 0};
        vecs[11] = '{1, 0, 0, 4, -1, 0, 2,  0, 0, 8, 0, 1};
        vecs[12] = '{1, 0, 0, 4, -1, 0, 2,  1, 0, 9, 1, 0};
        vecs[13] = '{1, 0, 0, 4, -1, 0, 2,  0, 0, 9, 0, 0};
        vecs[14] = '{1, 0, 0, 4, -1, 0, 2,  0, 0, 9, 0, 0};

        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; start = 1'b0; continuous = 1'b0;
        clear_obs();
        repeat (3) tick();
        check("reset_cap_en", cap_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", frame_err, 0);
        check("reset_cnt", frame_cnt, 0);
        check("reset_timeout", timeout, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 15; i++) begin
            start      = vecs[i].start;
            continuous = vecs[i].cont;
            clear_obs();
            run_frame(vecs[i].nl, vecs[i].sl, vecs[i].sb, vecs[i].tail, vecs[i].drop);
            check($sformatf("v%0d_done", i), done_seen, vecs[i].exp_done);
            if (vecs[i].exp_done != 0) check($sformatf("v%0d_err", i), err_last, vecs[i].exp_err);
            check($sformatf("v%0d_cnt", i), frame_cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d_cap", i), cap_hi, vecs[i].exp_cap ? href_ticks : 0);
            check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
        end

        // Reset asserted in the middle of a captured frame.
        continuous = 1'b1;
        start      = 1'b1;
        clear_obs();
        run_frame(4, -1, 0, 2, 0);
        href = 1'b1;
        repeat (3) tick();
        check("pre_reset_cap_en", cap_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_cap_en", cap_en, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_cnt", frame_cnt, 0);
        href = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            run_frame(4, -1, 0, 2, 0);
            check($sformatf("resettle_f%0d_done", f), done_seen, (f == 2) ? 1 : 0);
            check($sformatf("resettle_f%0d_cap", f), cap_hi, (f == 2) ? href_ticks : 0);
        end
        check("resettle_err", err_last, 0);
        check("resettle_cnt", frame_cnt, 1);

        // 255 more frames take the counter from 1 through 255 back to 0.
        clear_obs();
        for (int f = 0; f < 255; f++) run_frame(4, -1, 0, 2, 0);
        check("wrap_done_total", done_seen, 255);
        check("wrap_err_any", err_any, 0);
        check("wrap_cnt", frame_cnt, 0);

`ifdef OV7670_FRAME_TIMEOUT_EN
        begin
            int first = -1;
            clear_obs();
            check("wd_pre_cap_en", cap_en, 1);
            for (int c = 0; c < 150; c++) begin
                tick();
                if (timeout && first < 0) first = c;
            end
            check("wd_timeout", timeout, 1);
            check("wd_cycle_window", (first >= 90 && first <= 110) ? 1 : 0, 1);
            check("wd_cap_en", cap_en, 0);
            check("wd_busy", busy, 0);
            check("wd_no_done", done_seen, 0);
        end
`else
        repeat (150) tick();
        check("no_wd_timeout", timeout, 0);
        check("no_wd_cap_en", cap_en, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
